// File: rtl/hybrid_link_pkg.sv
// Shared definitions for the 32-bit hybrid link (transmitter and receiver).
//   link_state_e : transmitter FSM states
//   NXT_B0..B2   : receiver progress codes sent after bytes 0..2
//   byte_parity  : parity bit carried in beat[0] (XOR of the data byte)
//   make_beat    : {byte, parity}; a whole beat always XORs to 0
package hybrid_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_WAIT_NXT,
    ST_DONE,
    ST_ERR
  } link_state_e;

  localparam logic [1:0] NXT_B0 = 2'b01;
  localparam logic [1:0] NXT_B1 = 2'b10;
  localparam logic [1:0] NXT_B2 = 2'b11;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

  function automatic logic [8:0] make_beat(input logic [7:0] b);
    return {b, byte_parity(b)};
  endfunction

endpackage

// File: rtl/word_transmitter.sv
// Sends one 32-bit word over the 9-bit hybrid link bus as four beats,
// MSB byte first, each beat {byte, parity}.
// Ports:
//   clk, rst        : clock, async active-high reset
//   start, data_in  : launch request and word (sampled in IDLE only)
//   ready / ack     : request to the receiver and its acceptance
//   out_bus_9       : current beat, held between updates
//   nxt_data        : receiver progress code after bytes 0/1/2
//   busy, done, err : transfer in flight, success pulse, timeout pulse
// All outputs are registered. One counter serves both beat hold time and
// the ack/progress-code timeout; it saturates instead of wrapping.
module word_transmitter
  import hybrid_link_pkg::*;
#(
  parameter int HOLD_CYCLES = 12,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data_in,
  output logic        ready,
  input  logic        ack,
  output logic [8:0]  out_bus_9,
  input  logic [1:0]  nxt_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);

  link_state_e   state;
  logic [31:0]   word;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;

  logic [CW-1:0] cnt_inc;
  logic [1:0]    idx_nxt;
  logic [1:0]    code_exp;
  logic [7:0]    byte_nxt;

  always_comb begin
    cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
    idx_nxt  = idx + 2'd1;
    // Code the receiver sends once it has taken byte idx.
    code_exp = NXT_B2;
    case (idx)
      2'd0:    code_exp = NXT_B0;
      2'd1:    code_exp = NXT_B1;
      default: code_exp = NXT_B2;
    endcase
    byte_nxt = word[31:24];
    case (idx_nxt)
      2'd0:    byte_nxt = word[31:24];
      2'd1:    byte_nxt = word[23:16];
      2'd2:    byte_nxt = word[15:8];
      default: byte_nxt = word[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      word      <= '0;
      idx       <= '0;
      cnt       <= '0;
      ready     <= 1'b0;
      out_bus_9 <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            word  <= data_in;
            busy  <= 1'b1;
            ready <= 1'b1;
            cnt   <= '0;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack) begin
            ready     <= 1'b0;
            idx       <= 2'd0;
            out_bus_9 <= make_beat(word[31:24]);
            cnt       <= '0;
            state     <= ST_HOLD;
          end else if (cnt == ACK_LAST) begin
            // err/busy are updated on entry so the pulse and busy fall
            // appear in the same cycle as the ERR state.
            ready <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b1;
            state <= ST_ERR;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt <= '0;
            // The last byte gets no acknowledging code; hold expiry ends it.
            if (idx == 2'd3) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_WAIT_NXT;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_WAIT_NXT: begin
          if (nxt_data == code_exp) begin
            idx       <= idx_nxt;
            out_bus_9 <= make_beat(byte_nxt);
            cnt       <= '0;
            state     <= ST_HOLD;
          end else if (cnt == ACK_LAST) begin
            ready <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b1;
            state <= ST_ERR;
          end else begin
            cnt <= cnt_inc;
          end
        end
        // Exit cycles: start is deliberately not looked at here.
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_transmitter.sv
module tb_word_transmitter;

  localparam int H  = 12;
  localparam int AT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic        ready;
  logic        ack;
  logic [8:0]  out_bus_9;
  logic [1:0]  nxt_data;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  word_transmitter #(.HOLD_CYCLES(H), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .ready(ready),
    .ack(ack), .out_bus_9(out_bus_9), .nxt_data(nxt_data), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] beat_of(input logic [7:0] b);
    return {b, ^b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, out_bus_9);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(out_bus_9), 32'(e));
    end
  endtask

  // Start a word and get beat 0 accepted with an immediate ack.
  task automatic begin_word(input logic [31:0] w);
    exp_q.push_back(beat_of(w[31:24]));
    exp_q.push_back(beat_of(w[23:16]));
    exp_q.push_back(beat_of(w[15:8]));
    exp_q.push_back(beat_of(w[7:0]));
    data_in = w;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chk("ready_rise", 32'(ready), 32'd1);
    chk("busy_rise",  32'(busy),  32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ready_fall", 32'(ready), 32'd0);
    chk_beat("beat0");
  endtask

  // Present the code for the current beat; next beat is due HOLD+1 cycles on.
  task automatic next_beat(input logic [1:0] code, input string tag, input bit poke);
    nxt_data = code;
    for (int i = 0; i < H + 1; i++) begin
      if (poke && i == 2) begin
        data_in = 32'hDEAD_BEEF;
        start   = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk_beat(tag);
  endtask

  task automatic finish_word();
    repeat (H) tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_fall",  32'(busy), 32'd0);
    tick();
    chk("done_once",  32'(done), 32'd0);
    nxt_data = 2'b00;
  endtask

  task automatic send_word(input logic [31:0] w, input bit poke);
    begin_word(w);
    next_beat(2'b01, "beat1", poke);
    next_beat(2'b10, "beat2", 1'b0);
    next_beat(2'b11, "beat3", 1'b0);
    finish_word();
  endtask

  initial begin
    bit pulse_seen;
    rst = 1'b1; start = 1'b0; data_in = '0; ack = 1'b0; nxt_data = 2'b00;
    #3;
    chk("rst_bus",   32'(out_bus_9), 32'h0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Nominal word with prompt handshake.
    send_word(32'hA5C3_0F81, 1'b0);
    chk("bus_keeps_last", 32'(out_bus_9), 32'h102);

    // No ack: err exactly ACK_TIMEOUT cycles after ready rises.
    data_in = 32'h1234_5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_ready", 32'(ready), 32'd1);
    repeat (AT - 1) tick();
    chk("to_err_early", 32'(err), 32'd0);
    tick();
    chk("to_err",   32'(err),   32'd1);
    chk("to_ready0", 32'(ready), 32'd0);
    chk("to_busy0", 32'(busy),  32'd0);
    tick();
    chk("to_err_once", 32'(err), 32'd0);
    tick();

    // nxt_data stuck at 01 after beat 1: beat 1 held, then err.
    begin_word(32'h3C5A_9617);
    next_beat(2'b01, "stuck_beat1", 1'b0);
    repeat (H + AT - 1) tick();
    chk("stuck_err_early", 32'(err), 32'd0);
    tick();
    chk("stuck_err",  32'(err), 32'd1);
    chk("stuck_hold", 32'(out_bus_9), 32'(beat_of(8'h5A)));
    tick();
    chk("stuck_no_beat2", 32'(out_bus_9), 32'(beat_of(8'h5A)));
    exp_q.delete();
    nxt_data = 2'b00;
    tick();

    // Start pulsed mid-transfer is ignored.
    send_word(32'h0123_4567, 1'b1);
    tick();
    chk("ignored_start", 32'(busy), 32'd0);

    // Reset during HOLD of byte 2.
    begin_word(32'h89AB_CDEF);
    next_beat(2'b01, "rb_beat1", 1'b0);
    next_beat(2'b10, "rb_beat2", 1'b0);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("rb_bus",  32'(out_bus_9), 32'h0);
    chk("rb_outs", 32'({ready, busy, done, err}), 32'h0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    nxt_data = 2'b00;
    pulse_seen = 1'b0;
    for (int i = 0; i < H + 5; i++) begin
      tick();
      if (done || err || busy) pulse_seen = 1'b1;
    end
    chk("rb_quiet", 32'(pulse_seen), 32'd0);
    send_word(32'h7E81_42C3, 1'b0);

    // All-zero / all-one words.
    send_word(32'h0000_0000, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    chk("ones_last", 32'(out_bus_9), 32'h1FE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
